// File: rtl/md5_key_feeder.sv
// Brute-force key feeder for one md5_top core: writes the padded block, walks the charset odometer,
// and matches the delayed C/D digest words against a target to report the first hit index.
module md5_key_feeder #(
    parameter int unsigned PIPE_LAT = 64,  // must be >= 2
    parameter int unsigned MAX_LEN  = 8,
    parameter logic [7:0]  CH_MIN   = 8'h61,
    parameter logic [7:0]  CH_MAX   = 8'h7a,
    parameter int unsigned IDX_W    = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       len_in,
    input  logic [31:0]      target_c,
    input  logic [31:0]      target_d,
    output logic [5:0]       offset_out,
    output logic [7:0]       msbyte_out,
    input  logic [31:0]      c_in,
    input  logic [31:0]      d_in,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [IDX_W-1:0] hit_index
);

    localparam int unsigned POS_W = $clog2(MAX_LEN + 1);
    localparam int unsigned DR_W  = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRun,
        StCarry,
        StDrain,
        StDone
    } state_t;

    state_t             r_state;
    logic [3:0]         r_len;
    logic [7:0]         r_key [MAX_LEN];
    logic [POS_W-1:0]   r_pos;
    logic [5:0]         r_init_cnt;
    logic [DR_W-1:0]    r_drain_cnt;
    logic [5:0]         r_offset;
    logic [7:0]         r_byte;
    logic               r_tag;
    logic [PIPE_LAT-1:0] r_dly;
    logic [IDX_W-1:0]   r_out_count;
    logic               r_busy;
    logic               r_done;
    logic               r_hit;
    logic [IDX_W-1:0]   r_hit_index;

    logic               w_len_ok;
    logic               w_start_ok;
    logic               w_start_bad;
    logic [7:0]         w_key_pos;
    logic [7:0]         w_key_pos_next;
    logic [7:0]         w_key0_next;
    logic               w_key0_wrap;
    logic               w_key_pos_wrap;
    logic               w_pos_end;
    logic [15:0]        w_len_bits;
    logic [7:0]         w_init_byte;
    logic               w_tag_dly;
    logic               w_cd_eq;
    logic               w_match_active;

    assign w_len_ok    = (len_in != 4'd0) && (32'(len_in) <= MAX_LEN);
    assign w_start_ok  = (r_state == StIdle) && start && w_len_ok;
    assign w_start_bad = (r_state == StIdle) && start && !w_len_ok;

    always_comb begin
        w_key_pos = CH_MIN;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (r_pos == POS_W'(i)) begin
                w_key_pos = r_key[i];
            end
        end
    end

    assign w_key0_wrap    = (r_key[0] >= CH_MAX);
    assign w_key0_next    = w_key0_wrap ? CH_MIN : r_key[0] + 8'd1;
    assign w_key_pos_wrap = (w_key_pos >= CH_MAX);
    assign w_key_pos_next = w_key_pos_wrap ? CH_MIN : w_key_pos + 8'd1;
    assign w_pos_end      = (32'(r_pos) == 32'(r_len));

    // Padded single-block layout: key, 0x80 terminator, zeros, 64-bit little-endian bit length.
    assign w_len_bits = {9'd0, r_len, 3'd0};

    always_comb begin
        w_init_byte = 8'h00;
        if (r_init_cnt < {2'b00, r_len}) begin
            w_init_byte = CH_MIN;
        end else if (r_init_cnt == {2'b00, r_len}) begin
            w_init_byte = 8'h80;
        end else if (r_init_cnt == 6'd56) begin
            w_init_byte = w_len_bits[7:0];
        end else if (r_init_cnt == 6'd57) begin
            w_init_byte = w_len_bits[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_len       <= 4'd0;
            r_pos       <= '0;
            r_init_cnt  <= 6'd0;
            r_drain_cnt <= '0;
            r_offset    <= 6'd0;
            r_byte      <= 8'h00;
            r_tag       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_key[i] <= 8'h00;
            end
        end else begin
            r_tag <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start_ok) begin
                        r_len      <= len_in;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_init_cnt <= 6'd0;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            r_key[i] <= CH_MIN;
                        end
                        r_state <= StInit;
                    end else if (w_start_bad) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StInit: begin
                    r_offset   <= r_init_cnt;
                    r_byte     <= w_init_byte;
                    r_init_cnt <= r_init_cnt + 6'd1;
                    if (r_init_cnt == 6'd63) begin
                        r_tag   <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_offset <= 6'd0;
                    r_byte   <= w_key0_next;
                    r_key[0] <= w_key0_next;
                    if (!w_key0_wrap) begin
                        r_tag <= 1'b1;
                    end else begin
                        r_pos   <= POS_W'(1);
                        r_state <= StCarry;
                    end
                end
                StCarry: begin
                    if (w_pos_end) begin
                        // The exhaust cycle issues nothing and counts as the first drain cycle.
                        r_drain_cnt <= DR_W'(1);
                        r_state     <= StDrain;
                    end else begin
                        r_offset <= 6'(r_pos);
                        r_byte   <= w_key_pos_next;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (r_pos == POS_W'(i)) begin
                                r_key[i] <= w_key_pos_next;
                            end
                        end
                        if (!w_key_pos_wrap) begin
                            r_tag   <= 1'b1;
                            r_state <= StRun;
                        end else begin
                            r_pos <= r_pos + POS_W'(1);
                        end
                    end
                end
                StDrain: begin
                    r_drain_cnt <= r_drain_cnt + DR_W'(1);
                    if (r_drain_cnt >= DR_W'(PIPE_LAT - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_tag_dly      = r_dly[PIPE_LAT-1];
    assign w_cd_eq        = (c_in == target_c) && (d_in == target_d);
    assign w_match_active = (r_state == StInit) || (r_state == StRun) ||
                            (r_state == StCarry) || (r_state == StDrain);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dly       <= '0;
            r_out_count <= '0;
            r_hit       <= 1'b0;
            r_hit_index <= '0;
        end else begin
            r_dly <= {r_dly[PIPE_LAT-2:0], r_tag};
            if (w_start_ok) begin
                r_out_count <= '0;
                r_hit       <= 1'b0;
                r_hit_index <= '0;
            end else if (w_start_bad) begin
                r_hit       <= 1'b0;
                r_hit_index <= '0;
            end else if (w_match_active && w_tag_dly) begin
                r_out_count <= r_out_count + IDX_W'(1);
                if (w_cd_eq && !r_hit) begin
                    r_hit       <= 1'b1;
                    r_hit_index <= r_out_count;
                end
            end
        end
    end

    assign offset_out = r_offset;
    assign msbyte_out = r_byte;
    assign busy       = r_busy;
    assign done       = r_done;
    assign hit        = r_hit;
    assign hit_index  = r_hit_index;

endmodule

// File: tb/tb_md5_key_feeder.sv
// Bench for md5_key_feeder: a behavioural md5_top (real MD5 compression, PIPE_LAT delay) plus a
// scoreboard of expected run results popped whenever done rises.
module tb_md5_key_feeder;

    localparam int unsigned PIPE_LAT = 64;
    localparam int unsigned IDX_W    = 48;
    localparam logic [7:0]  CH_MIN   = 8'h61;
    localparam logic [7:0]  CH_MAX   = 8'h7a;

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int MD5_S [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    // md5("c") = 4a8a08f0 9d37b737 95649038 408b5f33 -> C, D little-endian words
    localparam logic [31:0] C_OF_C = 32'h38906495;
    localparam logic [31:0] D_OF_C = 32'h335f8b40;

    logic             clk;
    logic             reset;
    logic             start;
    logic [3:0]       len_in;
    logic [31:0]      target_c;
    logic [31:0]      target_d;
    logic [5:0]       offset_out;
    logic [7:0]       msbyte_out;
    logic [31:0]      c_in;
    logic [31:0]      d_in;
    logic             busy;
    logic             done;
    logic             hit;
    logic [IDX_W-1:0] hit_index;

    md5_key_feeder #(
        .PIPE_LAT(PIPE_LAT),
        .MAX_LEN (8),
        .CH_MIN  (CH_MIN),
        .CH_MAX  (CH_MAX),
        .IDX_W   (IDX_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len_in    (len_in),
        .target_c  (target_c),
        .target_d  (target_d),
        .offset_out(offset_out),
        .msbyte_out(msbyte_out),
        .c_in      (c_in),
        .d_in      (d_in),
        .busy      (busy),
        .done      (done),
        .hit       (hit),
        .hit_index (hit_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] put_byte(input logic [511:0] b, input logic [5:0] o,
                                              input logic [7:0] v);
        logic [511:0] r;
        r = b;
        r[{o, 3'b000} +: 8] = v;
        return r;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // Single-block MD5 compression; returns {C, D}.
    function automatic logic [63:0] md5_cd(input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, t;
        int g;
        a = 32'h67452301;
        b = 32'hefcdab89;
        c = 32'h98badcfe;
        d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0: begin f = (b & c) | (~b & d); g = i; end
                1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
            endcase
            t = d;
            d = c;
            c = b;
            b = b + rotl(a + f + MD5_K[i] + blk[32*g +: 32], MD5_S[(i / 16) * 4 + (i % 4)]);
            a = t;
        end
        return {32'h98badcfe + c, 32'h10325476 + d};
    endfunction

    logic [511:0] core_blk;
    logic [63:0]  cd_pipe [PIPE_LAT];

    always @(posedge clk) begin
        core_blk   <= put_byte(core_blk, offset_out, msbyte_out);
        cd_pipe[0] <= md5_cd(put_byte(core_blk, offset_out, msbyte_out));
        for (int i = 1; i < PIPE_LAT; i++) cd_pipe[i] <= cd_pipe[i-1];
    end

    assign c_in = cd_pipe[PIPE_LAT-1][63:32];
    assign d_in = cd_pipe[PIPE_LAT-1][31:0];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic             hit;
        logic [IDX_W-1:0] idx;
        int               ntag;
        bit               full;
    } exp_t;

    exp_t sb[$];
    int   cur_len = 0;

    // Monitor: counts candidate writes and scores each run when done rises.
    initial begin
        int   cyc = 0;
        int   last_chg = 0;
        int   vcount = 0;
        logic [13:0] prev_w = '0;
        logic prev_busy = 1'b0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if ({offset_out, msbyte_out} != prev_w) begin
                last_chg = cyc;
                prev_w   = {offset_out, msbyte_out};
            end
            if (busy && !prev_busy) begin
                vcount = 1;
            end else if (busy && int'(offset_out) < cur_len && msbyte_out > CH_MIN &&
                         msbyte_out <= CH_MAX) begin
                vcount++;
            end
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: done rose with no run outstanding (t=%0t)",
                             $time);
                end else begin
                    e = sb.pop_front();
                    check("hit", 64'(hit), 64'(e.hit));
                    check("hit_index", 64'(hit_index), 64'(e.idx));
                    check("busy_at_done", 64'(busy), 64'(0));
                    if (e.full) begin
                        check("valid_tags", 64'(vcount), 64'(e.ntag));
                        check("done_latency", 64'(cyc - last_chg), 64'(PIPE_LAT));
                    end
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
    end

    function automatic logic [7:0] init_exp(input int l, input int k);
        if (k < l) return CH_MIN;
        if (k == l) return 8'h80;
        if (k == 56) return 8'(l * 8);
        if (k == 57) return 8'((l * 8) >> 8);
        return 8'h00;
    endfunction

    task automatic do_start(input int l);
        @(negedge clk);
        len_in = 4'(l);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic push(input logic h, input logic [IDX_W-1:0] idx, input int ntag, input bit full);
        exp_t e;
        e.hit  = h;
        e.idx  = idx;
        e.ntag = ntag;
        e.full = full;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: done still %0b after %0d cycles, expected 1", done, n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_offset"}, 64'(offset_out), 64'(0));
        check({tag, "_msbyte"}, 64'(msbyte_out), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_hit"}, 64'(hit), 64'(0));
        check({tag, "_hit_index"}, 64'(hit_index), 64'(0));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic bad_len_run(input int l);
        int busy_seen = 0;
        pulse_reset();
        push(1'b0, '0, 0, 1'b0);
        cur_len = 0;
        do_start(l);
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        check("bad_len_busy_cycles", 64'(busy_seen), 64'(0));
        check("bad_len_done", 64'(done), 64'(1));
    endtask

    initial begin
        int found;
        reset    = 1'b1;
        start    = 1'b0;
        len_in   = 4'd0;
        target_c = 32'h0;
        target_d = 32'h0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        // L=3, target md5("abc"): index = 0 + 1*26 + 2*676
        cur_len  = 3;
        target_c = 32'h7d3f96d6;
        target_d = 32'h727fe128;
        push(1'b1, IDX_W'(1378), 17576, 1'b1);
        do_start(3);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (offset_out == 6'd0 && msbyte_out == CH_MIN) found = 1;
            else @(negedge clk);
        end
        check("init_first_write_seen", 64'(found), 64'(1));
        for (int k = 0; k < 64; k++) begin
            check("init_offset", 64'(offset_out), 64'(k));
            check("init_byte", 64'(msbyte_out), 64'(init_exp(3, k)));
            @(negedge clk);
        end
        wait_done(25000);

        // L=1, target md5("c"): third candidate
        cur_len  = 1;
        target_c = C_OF_C;
        target_d = D_OF_C;
        push(1'b1, IDX_W'(2), 26, 1'b1);
        do_start(1);
        wait_done(500);

        // L=2, unreachable target, plus a start pulse while busy that must be ignored
        cur_len  = 2;
        target_c = 32'h0;
        target_d = 32'h0;
        push(1'b0, '0, 676, 1'b1);
        do_start(2);
        repeat (50) @(negedge clk);
        len_in = 4'd1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_after_ignored_start", 64'(busy), 64'(1));
        wait_done(2000);

        // Reset 100 cycles into an L=2 run, then a clean L=1 run
        cur_len = 2;
        do_start(2);
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero_outputs("midrun_reset");
        @(negedge clk);
        reset    = 1'b0;
        cur_len  = 1;
        target_c = C_OF_C;
        target_d = D_OF_C;
        push(1'b1, IDX_W'(2), 26, 1'b1);
        do_start(1);
        wait_done(500);

        bad_len_run(0);
        bad_len_run(9);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/md5_key_feeder.md
Name: md5_key_feeder

Overview:
- Brute-force driver for one md5_top core. Owns the write side: it initialises the 64-byte message block, then streams candidate keys one byte write per cycle on offset/msbyte.
- Owns the read side: it tracks which writes produced complete candidates, delays that tag by the core's latency, and compares the returned C/D words against a target.
- Reports the first matching candidate's sequence index.
- One instance sits beside each md5_top; a host/UART layer above provides start, length and target.

Parameters:
- PIPE_LAT, 64, cycles from a write at md5_top inputs to the matching c_out/d_out.
- MAX_LEN, 8, maximum key length in bytes (≤ 55).
- CH_MIN, 8'h61, lowest charset byte.
- CH_MAX, 8'h7a, highest charset byte (must be ≥ CH_MIN).
- IDX_W, 48, width of candidate index counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a run when idle.
- len_in  in  4  key length, sampled on start.
- target_c  in  32  expected C word.
- target_d  in  32  expected D word.
- offset_out  out  6  byte offset, to md5_top offset_in.
- msbyte_out  out  8  byte value, to md5_top msbyte_in.
- c_in  in  32  from md5_top c_out.
- d_in  in  32  from md5_top d_out.
- busy  out  1  run in progress.
- done  out  1  run finished; sticky until next start.
- hit  out  1  match found; sticky until next start.
- hit_index  out  IDX_W  index of first matching candidate.

Behaviour:
- Reset (async): state IDLE; offset_out=0, msbyte_out=0, busy=0, done=0, hit=0, hit_index=0; tag delay line, key byte registers and counters cleared. Reset mid-run aborts with no further writes.
- Interface contract: the write presented in cycle t completes the block whose digest appears on c_in/d_in in cycle t+PIPE_LAT, tagged by the write's valid bit. C/D are MD5 state words (digest bytes 8..11 and 12..15, little-endian).
- Candidate ordering: byte 0 is the least significant digit, radix R=CH_MAX-CH_MIN+1. The index counts valid candidates from 0.
- IDLE: outputs hold. start with 1≤len_in≤MAX_LEN clears done/hit/hit_index and out_count, sets busy, and enters INIT. start with len_in=0 or >MAX_LEN goes directly to DONE (done=1, hit=0). start while busy is ignored.
- INIT: 64 cycles, offset 0..63:
  - bytes 0..L-1 = CH_MIN
  - byte L = 8'h80
  - bytes L+1..55 = 0
  - byte 56 = (L*8)[7:0], byte 57 = (L*8)>>8, bytes 58..63 = 0
  - Tag valid only on the offset-63 write (candidate 0 = all CH_MIN). Next state RUN.
- RUN: if key[0]<CH_MAX, write offset 0 with key[0]+1, tag valid. Else write CH_MIN, tag invalid, pos=1, go CARRY.
- CARRY:
  - pos==L: exhausted, tag invalid, go DRAIN.
  - key[pos]<CH_MAX: write key[pos]+1, tag valid, go RUN.
  - Otherwise: write CH_MIN, tag invalid, pos+1, stay in CARRY.
- Total valid tags per run = R^L.
- DRAIN: no valid tags issued; offset/byte hold. Lasts PIPE_LAT cycles, then DONE.
- DONE: busy=0, done=1, go IDLE.
- Match side, active in INIT/RUN/CARRY/DRAIN:
  - When the delayed tag is 1 and {c_in,d_in}=={target_c,target_d} and hit=0, set hit=1 and hit_index=out_count in the same cycle.
  - out_count increments on every delayed valid tag and wraps modulo 2^IDX_W.
  - Later matches are ignored; the run continues to exhaustion.
- Invalid-tag outputs are never compared.

Test Plan:
- Reset mid-RUN (after 100 cycles): outputs zero next cycle. A subsequent start with L=1 runs cleanly.
- INIT check, L=3: offset 0..63 sequence shows 61 61 61 80 00… with byte 56=0x18, 57..63=0. Exactly one valid tag during INIT.
- L=1, charset a..z, target = md5("c") C/D: hit=1, hit_index=2. done asserts exactly PIPE_LAT cycles after the exhaust cycle. 26 valid tags total.
- L=3, target_c=32'h7d3f96d6, target_d=32'h727fe128 (md5 "abc"): hit_index=1378.
- L=2, unreachable target: hit=0, done=1. 676 valid tags; carry cycles never tagged valid.
- start with len_in=0, then len_in=9: immediate done=1, busy never rises. start pulsed while busy: no effect.
